ccc_csr_writeback: RTL and testbench

// Write-side counterpart of the CSR field extraction. Captures address and limit updates from decoded

---
 rtl/ccc_csr_writeback.sv | 171 +++++++++++++++++
 tb/tb_ccc_csr_writeback.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ccc_csr_writeback.sv
`default_nettype none
// ============================================================================
// ccc_csr_writeback: commits CCC-driven dynamic address updates to the CSR
// block via req/ack and holds the GETMWL/GETMRL/GETIBIL limits.
// Revision: 1.0
// ============================================================================
module ccc_csr_writeback #(
  parameter logic [15:0] DefMwl  = 16'd256,
  parameter logic [15:0] DefMrl  = 16'd256,
  parameter logic [7:0]  DefIbil = 8'd255,
  parameter logic [15:0] MinLen  = 16'd8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rstdaa_i,
  input  logic        setdasa_i,
  input  logic        setnewda_i,
  input  logic [6:0]  addr_i,
  input  logic        virt_i,
  input  logic        dyn_valid_i,
  input  logic        virt_dyn_valid_i,
  input  logic        sw_busy_i,
  input  logic        set_mwl_i,
  input  logic [15:0] mwl_i,
  input  logic        set_mrl_i,
  input  logic [15:0] mrl_i,
  input  logic        set_ibil_i,
  input  logic [7:0]  ibil_i,
  output logic        csr_req_o,
  input  logic        csr_ack_i,
  output logic        csr_virt_o,
  output logic [6:0]  csr_addr_o,
  output logic        csr_addr_valid_o,
  output logic [15:0] get_mwl_o,
  output logic [15:0] get_mrl_o,
  output logic [7:0]  get_ibil_o,
  output logic        evt_o,
  output logic [1:0]  evt_code_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_NOTIFY = 2'd2
  } state_t;

  localparam logic [1:0] C_CODE_RSTDAA = 2'd0;
  localparam logic [1:0] C_CODE_DASA   = 2'd1;
  localparam logic [1:0] C_CODE_NEWDA  = 2'd2;

  state_t r_state;
  state_t w_state_nxt;

  logic       r_p_pend, r_p_valid;
  logic [6:0] r_p_addr;
  logic [1:0] r_p_code;
  logic       r_v_pend, r_v_valid;
  logic [6:0] r_v_addr;
  logic [1:0] r_v_code;
  logic [1:0] r_code;

  logic       w_tgt_valid;
  logic       w_dasa_ok, w_newda_ok;
  logic       w_p_hit, w_v_hit;
  logic       w_ev_valid;
  logic [6:0] w_ev_addr;
  logic [1:0] w_ev_code;
  logic       w_launch, w_serve_p, w_serve_v;

  // Filtering uses the target's valid bit as seen in the arrival cycle.
  always_comb begin
    w_tgt_valid = virt_i ? virt_dyn_valid_i : dyn_valid_i;
    w_dasa_ok   = setdasa_i && !w_tgt_valid;
    w_newda_ok  = setnewda_i && w_tgt_valid;
    w_ev_valid  = 1'b1;
    w_ev_addr   = addr_i;
    w_ev_code   = w_newda_ok ? C_CODE_NEWDA : C_CODE_DASA;
    if (rstdaa_i) begin
      w_ev_valid = 1'b0;
      w_ev_addr  = 7'd0;
      w_ev_code  = C_CODE_RSTDAA;
    end
    w_p_hit = rstdaa_i || ((w_dasa_ok || w_newda_ok) && !virt_i);
    w_v_hit = rstdaa_i || ((w_dasa_ok || w_newda_ok) && virt_i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_p_pend || r_v_pend) && !sw_busy_i) begin
          w_launch    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:    if (csr_ack_i) w_state_nxt = S_NOTIFY;
      S_NOTIFY: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    w_serve_p = w_launch && r_p_pend;
    w_serve_v = w_launch && !r_p_pend;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A hit in the same cycle as a launch re-arms the slot rather than clearing it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p_pend <= 1'b0; r_p_valid <= 1'b0; r_p_addr <= 7'd0; r_p_code <= 2'd0;
      r_v_pend <= 1'b0; r_v_valid <= 1'b0; r_v_addr <= 7'd0; r_v_code <= 2'd0;
    end else begin
      if (w_p_hit) begin
        r_p_pend  <= 1'b1;
        r_p_valid <= w_ev_valid;
        r_p_addr  <= w_ev_addr;
        r_p_code  <= w_ev_code;
      end else if (w_serve_p) begin
        r_p_pend  <= 1'b0;
      end
      if (w_v_hit) begin
        r_v_pend  <= 1'b1;
        r_v_valid <= w_ev_valid;
        r_v_addr  <= w_ev_addr;
        r_v_code  <= w_ev_code;
      end else if (w_serve_v) begin
        r_v_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_virt_o       <= 1'b0;
      csr_addr_o       <= 7'd0;
      csr_addr_valid_o <= 1'b0;
      r_code           <= 2'd0;
    end else if (w_serve_p) begin
      csr_virt_o       <= 1'b0;
      csr_addr_o       <= r_p_addr;
      csr_addr_valid_o <= r_p_valid;
      r_code           <= r_p_code;
    end else if (w_serve_v) begin
      csr_virt_o       <= 1'b1;
      csr_addr_o       <= r_v_addr;
      csr_addr_valid_o <= r_v_valid;
      r_code           <= r_v_code;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      get_mwl_o  <= DefMwl;
      get_mrl_o  <= DefMrl;
      get_ibil_o <= DefIbil;
    end else begin
      if (set_mwl_i)  get_mwl_o  <= (mwl_i < MinLen) ? MinLen : mwl_i;
      if (set_mrl_i)  get_mrl_o  <= (mrl_i < MinLen) ? MinLen : mrl_i;
      if (set_ibil_i) get_ibil_o <= ibil_i;
    end
  end

  assign csr_req_o  = (r_state == S_REQ);
  assign evt_o      = (r_state == S_NOTIFY);
  assign evt_code_o = (r_state == S_NOTIFY) ? r_code : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_ccc_csr_writeback.sv
`default_nettype none
// ============================================================================
// tb_ccc_csr_writeback: directed self-checking bench for ccc_csr_writeback.
// Revision: 1.0
// ============================================================================
module tb_ccc_csr_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        rstdaa, setdasa, setnewda, virt, dyn_valid, virt_dyn_valid, sw_busy;
  logic [6:0]  addr;
  logic        set_mwl, set_mrl, set_ibil;
  logic [15:0] mwl, mrl;
  logic [7:0]  ibil;
  logic        csr_req, csr_ack, csr_virt, csr_addr_valid, evt;
  logic [6:0]  csr_addr;
  logic [15:0] get_mwl, get_mrl;
  logic [7:0]  get_ibil;
  logic [1:0]  evt_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ccc_csr_writeback dut (
    .clk_i(clk), .rst_i(rst),
    .rstdaa_i(rstdaa), .setdasa_i(setdasa), .setnewda_i(setnewda),
    .addr_i(addr), .virt_i(virt),
    .dyn_valid_i(dyn_valid), .virt_dyn_valid_i(virt_dyn_valid),
    .sw_busy_i(sw_busy),
    .set_mwl_i(set_mwl), .mwl_i(mwl),
    .set_mrl_i(set_mrl), .mrl_i(mrl),
    .set_ibil_i(set_ibil), .ibil_i(ibil),
    .csr_req_o(csr_req), .csr_ack_i(csr_ack), .csr_virt_o(csr_virt),
    .csr_addr_o(csr_addr), .csr_addr_valid_o(csr_addr_valid),
    .get_mwl_o(get_mwl), .get_mrl_o(get_mrl), .get_ibil_o(get_ibil),
    .evt_o(evt), .evt_code_o(evt_code)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic v,
                         input logic [6:0] a, input logic av);
    chk({tag, "_req"}, {31'd0, csr_req}, {31'd0, req});
    chk({tag, "_virt"}, {31'd0, csr_virt}, {31'd0, v});
    chk({tag, "_addr"}, {25'd0, csr_addr}, {25'd0, a});
    chk({tag, "_aval"}, {31'd0, csr_addr_valid}, {31'd0, av});
  endtask

  task automatic chk_evt(input string tag, input logic e, input logic [1:0] c);
    chk({tag, "_evt"}, {31'd0, evt}, {31'd0, e});
    chk({tag, "_code"}, {30'd0, evt_code}, {30'd0, c});
    chk({tag, "_req0"}, {31'd0, csr_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rstdaa = 0; setdasa = 0; setnewda = 0; virt = 0; addr = '0;
    dyn_valid = 0; virt_dyn_valid = 0; sw_busy = 0; csr_ack = 0;
    set_mwl = 0; set_mrl = 0; set_ibil = 0; mwl = '0; mrl = '0; ibil = '0;
    tick(2);
    rst = 1'b0;

    chk("rst_mwl", {16'd0, get_mwl}, 32'd256);
    chk("rst_mrl", {16'd0, get_mrl}, 32'd256);
    chk("rst_ibil", {24'd0, get_ibil}, 32'd255);
    chk_req("rst", 1'b0, 1'b0, 7'h00, 1'b0);
    chk_evt("rst", 1'b0, 2'd0);

    // Length limits
    set_mwl = 1; mwl = 16'd4; tick(); set_mwl = 0;
    chk("mwl_clamp", {16'd0, get_mwl}, 32'd8);
    set_mrl = 1; mrl = 16'h0400; tick(); set_mrl = 0;
    chk("mrl_0400", {16'd0, get_mrl}, 32'h400);
    set_ibil = 1; ibil = 8'd3; tick(); set_ibil = 0;
    chk("ibil_noclamp", {24'd0, get_ibil}, 32'd3);
    set_mwl = 1; mwl = 16'd8; tick(); set_mwl = 0;
    chk("mwl_eq_min", {16'd0, get_mwl}, 32'd8);
    set_mrl = 1; mrl = 16'd7; tick(); set_mrl = 0;
    chk("mrl_clamp", {16'd0, get_mrl}, 32'd8);

    // SETDASA with physical valid=0, ack after two REQ cycles
    setdasa = 1; addr = 7'h2A; virt = 0; tick(); setdasa = 0;
    chk_req("dasa_idle", 1'b0, 1'b0, 7'h00, 1'b0);
    tick();
    chk_req("dasa_req1", 1'b1, 1'b0, 7'h2A, 1'b1);
    tick();
    chk_req("dasa_req2", 1'b1, 1'b0, 7'h2A, 1'b1);
    csr_ack = 1; tick(); csr_ack = 0;
    chk_evt("dasa_evt", 1'b1, 2'd1);
    tick();
    chk_evt("dasa_done", 1'b0, 2'd0);

    // SETDASA filtered when valid=1, then SETNEWDA accepted
    dyn_valid = 1;
    setdasa = 1; addr = 7'h55; tick(); setdasa = 0;
    tick(2);
    chk("dasa_filtered", {31'd0, csr_req}, 32'd0);
    setnewda = 1; addr = 7'h33; tick(); setnewda = 0;
    tick();
    chk_req("newda_req", 1'b1, 1'b0, 7'h33, 1'b1);
    csr_ack = 1; tick(); csr_ack = 0;
    chk_evt("newda_evt", 1'b1, 2'd2);
    tick();

    // SETNEWDA with physical valid=0 is filtered
    dyn_valid = 0;
    setnewda = 1; addr = 7'h12; tick(); setnewda = 0;
    tick(2);
    chk("newda_filtered", {31'd0, csr_req}, 32'd0);

    // Virtual target SETNEWDA
    virt_dyn_valid = 1;
    setnewda = 1; virt = 1; addr = 7'h44; tick(); setnewda = 0; virt = 0;
    tick();
    chk_req("vnewda_req", 1'b1, 1'b1, 7'h44, 1'b1);
    csr_ack = 1; tick(); csr_ack = 0;
    chk_evt("vnewda_evt", 1'b1, 2'd2);
    tick();

    // RSTDAA: physical then virtual commits
    rstdaa = 1; tick(); rstdaa = 0;
    tick();
    chk_req("rst_p_req", 1'b1, 1'b0, 7'h00, 1'b0);
    csr_ack = 1; tick();
    chk_evt("rst_p_evt", 1'b1, 2'd0);
    tick();
    chk_evt("rst_gap", 1'b0, 2'd0);
    tick();
    chk_req("rst_v_req", 1'b1, 1'b1, 7'h00, 1'b0);
    tick(); csr_ack = 0;
    chk_evt("rst_v_evt", 1'b1, 2'd0);
    tick(2);
    chk_evt("rst_idle", 1'b0, 2'd0);

    // sw_busy holds off the request; latest event wins
    sw_busy = 1;
    setdasa = 1; addr = 7'h10; tick();
    addr = 7'h11; tick(); setdasa = 0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_hold", {31'd0, csr_req}, 32'd0);
      tick();
    end
    sw_busy = 0; tick();
    chk_req("busy_req", 1'b1, 1'b0, 7'h11, 1'b1);
    csr_ack = 1; tick(); csr_ack = 0;
    chk_evt("busy_evt", 1'b1, 2'd1);
    tick(2);
    chk_evt("busy_single", 1'b0, 2'd0);

    // Reset during REQ abandons the request
    setdasa = 1; addr = 7'h05; tick(); setdasa = 0;
    tick();
    chk("midreq_req", {31'd0, csr_req}, 32'd1);
    rst = 1; tick(); rst = 0;
    chk_req("midreq_rst", 1'b0, 1'b0, 7'h00, 1'b0);
    chk("midreq_mwl", {16'd0, get_mwl}, 32'd256);
    tick(2);
    chk_evt("midreq_noevt", 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
